// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, redirect request and decode handshake.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    logic [31:0]            imem_a;
    logic [31:0]            imem_rd;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   inst_valid;
    logic [31:0]            inst;
    logic [31:0]            inst_pc;
    logic [31:0]            inst_pc8;
    logic                   inst_ready;
    logic [$clog2(DEPTH):0] count;

    // Fetch-queue side
    modport master (
        output imem_a, inst_valid, inst, inst_pc, inst_pc8, count,
        input  imem_rd, redirect, redirect_pc, inst_ready
    );

    // Environment side: memory, branch unit and decode
    modport slave (
        input  imem_a, inst_valid, inst, inst_pc, inst_pc8, count,
        output imem_rd, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction memory and buffers
// {word, pc} pairs in a show-ahead FIFO feeding decode. Redirect flushes and restarts fetch.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);
    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     mem_inst_q [DEPTH];
    logic [31:0]     mem_pc_q   [DEPTH];

    logic pop;
    logic push;

    // Handshake decode; a full queue only accepts a word when the head leaves the same cycle
    always_comb begin
        pop  = (count_q != '0) && bus.inst_ready;
        push = !bus.redirect && ((count_q != Full) || pop);
    end

    // Next-state for PC, pointers and occupancy; redirect overrides everything
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PtrW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= ResetPcAligned;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents after a flush are stale but masked by inst_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_inst_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else if (push) begin
            mem_inst_q[wr_ptr_q] <= bus.imem_rd;
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    // Show-ahead outputs straight from the head entry
    always_comb begin
        bus.imem_a     = {fetch_pc_q[31:2], 2'b00};
        bus.inst_valid = (count_q != '0);
        bus.inst       = mem_inst_q[rd_ptr_q];
        bus.inst_pc    = mem_pc_q[rd_ptr_q];
        bus.inst_pc8   = mem_pc_q[rd_ptr_q] + 32'd8;
        bus.count      = count_q;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a reference model keeps the expected fetch PC and a
// scoreboard queue of fetched PCs; each test compares DUT outputs against it every cycle.
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned CntW     = $clog2(DEPTH) + 1;

    logic clk;
    logic reset;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hE000_0000 + (a >> 2);
    endfunction

    // Combinational instruction memory
    assign bus.imem_rd = word_at(bus.imem_a);

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_q[$];

    task automatic apply_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_q.delete();
        m_pc = RESET_PC & ~32'h3;
    endtask

    // One clock: advance the model with the inputs present at the edge, return at negedge
    task automatic step();
        bit pop, push;
        pop  = (m_q.size() != 0) && bus.inst_ready;
        push = !bus.redirect && ((m_q.size() < DEPTH) || pop);
        @(posedge clk);
        if (bus.redirect) begin
            m_q.delete();
            m_pc = bus.redirect_pc & ~32'h3;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        #2;
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid);
        end
        n_checks++;
        if (bus.count !== CntW'(0)) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count);
        end
        n_checks++;
        if (bus.imem_a !== RESET_PC) begin
            n_fail++; $display("FAIL reset_imem_a: got %h want %h", bus.imem_a, RESET_PC);
        end
        n_checks++;
        if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_pc8 !== 32'h8) begin
            n_fail++;
            $display("FAIL reset_head: got inst=%h pc=%h pc8=%h want 0/0/8",
                     bus.inst, bus.inst_pc, bus.inst_pc8);
        end
        apply_reset();
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        apply_reset();
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_pc = 32'(i) * 32'd4;
            n_checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL free_run_pc[%0d]: got v=%b pc=%h want v=1 pc=%h",
                         i, bus.inst_valid, bus.inst_pc, exp_pc);
            end
            n_checks++;
            if (bus.inst !== word_at(exp_pc) || bus.inst_pc8 !== exp_pc + 32'd8) begin
                n_fail++;
                $display("FAIL free_run_data[%0d]: got inst=%h pc8=%h want %h/%h",
                         i, bus.inst, bus.inst_pc8, word_at(exp_pc), exp_pc + 32'd8);
            end
            n_checks++;
            if (bus.count !== CntW'(1)) begin
                n_fail++; $display("FAIL free_run_count[%0d]: got %0d want 1", i, bus.count);
            end
        end
    endtask

    task automatic test_full_stall();
        int unsigned exp_cnt;
        apply_reset();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            exp_cnt = (i + 1 < int'(DEPTH)) ? i + 1 : DEPTH;
            n_checks++;
            if (bus.count !== CntW'(exp_cnt) || bus.count !== CntW'(m_q.size())) begin
                n_fail++;
                $display("FAIL stall_count[%0d]: got %0d want %0d", i, bus.count, exp_cnt);
            end
        end
        n_checks++;
        if (bus.imem_a !== 32'h10) begin
            n_fail++; $display("FAIL stall_imem_a: got %h want 00000010", bus.imem_a);
        end
        n_checks++;
        if (bus.inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL stall_head: got %h want 00000000", bus.inst_pc);
        end
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        n_checks++;
        if (bus.count !== CntW'(4) || bus.imem_a !== 32'h14) begin
            n_fail++;
            $display("FAIL full_pop_push: got count=%0d imem_a=%h want 4/00000014",
                     bus.count, bus.imem_a);
        end
        n_checks++;
        if (bus.inst_pc !== 32'h4 || bus.inst !== word_at(32'h4)) begin
            n_fail++;
            $display("FAIL full_pop_head: got pc=%h inst=%h want 00000004/%h",
                     bus.inst_pc, bus.inst, word_at(32'h4));
        end
        // Drain and confirm order 8, C, 10 with no loss or duplication
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.inst_pc !== m_q[0] || bus.inst_pc !== 32'(8 + 4 * i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, bus.inst_pc, 32'(8 + 4 * i));
            end
        end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_redirect();
        apply_reset();
        bus.inst_ready = 1'b0;
        repeat (4) step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_010B;
        step();
        bus.redirect = 1'b0;
        n_checks++;
        if (bus.count !== CntW'(0) || bus.inst_valid !== 1'b0 || bus.imem_a !== 32'h108) begin
            n_fail++;
            $display("FAIL redirect_flush: got count=%0d v=%b imem_a=%h want 0/0/00000108",
                     bus.count, bus.inst_valid, bus.imem_a);
        end
        step();
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h108 || bus.inst_pc8 !== 32'h110) begin
            n_fail++;
            $display("FAIL redirect_first: got v=%b pc=%h pc8=%h want 1/00000108/00000110",
                     bus.inst_valid, bus.inst_pc, bus.inst_pc8);
        end
    endtask

    task automatic test_redirect_held();
        logic [31:0] targets [3];
        targets[0] = 32'h0000_0200;
        targets[1] = 32'h0000_0305;
        targets[2] = 32'h0000_040C;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.redirect = 1'b1;
            bus.redirect_pc = targets[i];
            step();
            n_checks++;
            if (bus.inst_valid !== 1'b0 || bus.imem_a !== (targets[i] & ~32'h3)) begin
                n_fail++;
                $display("FAIL redirect_held[%0d]: got v=%b imem_a=%h want 0/%h",
                         i, bus.inst_valid, bus.imem_a, targets[i] & ~32'h3);
            end
        end
        bus.redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(32'h40C + 4 * i)) begin
                n_fail++;
                $display("FAIL redirect_resume[%0d]: got v=%b pc=%h want 1/%h",
                         i, bus.inst_valid, bus.inst_pc, 32'(32'h40C + 4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'hFFFF_FFF8;
        exp_seq[1] = 32'hFFFF_FFFC;
        exp_seq[2] = 32'h0000_0000;
        exp_seq[3] = 32'h0000_0004;
        bus.inst_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        step();
        bus.redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_seq[i]
                || bus.inst !== word_at(exp_seq[i])) begin
                n_fail++;
                $display("FAIL wrap_pc[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h", i,
                         bus.inst_valid, bus.inst_pc, bus.inst, exp_seq[i], word_at(exp_seq[i]));
            end
            n_checks++;
            if (bus.inst_pc8 !== exp_seq[i] + 32'd8) begin
                n_fail++;
                $display("FAIL wrap_pc8[%0d]: got %h want %h", i, bus.inst_pc8,
                         exp_seq[i] + 32'd8);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.inst_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if (bus.count !== CntW'(3)) begin
            n_fail++; $display("FAIL async_pre_count: got %0d want 3", bus.count);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.count !== CntW'(0) || bus.imem_a !== RESET_PC) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b count=%0d imem_a=%h want 0/0/%h",
                     bus.inst_valid, bus.count, bus.imem_a, RESET_PC);
        end
        @(negedge clk);
        reset = 1'b0;
        m_q.delete();
        m_pc = RESET_PC;
        step();
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RESET_PC || bus.count !== CntW'(1)) begin
            n_fail++;
            $display("FAIL async_resume: got v=%b pc=%h count=%0d want 1/%h/1",
                     bus.inst_valid, bus.inst_pc, bus.count, RESET_PC);
        end
    endtask

    // Random ready / occasional redirect, every cycle checked against the scoreboard
    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            bus.inst_ready = 1'($urandom_range(0, 1));
            bus.redirect = ($urandom_range(0, 9) == 0);
            bus.redirect_pc = $urandom;
            step();
            n_checks++;
            if (bus.count !== CntW'(m_q.size()) || bus.imem_a !== m_pc
                || bus.inst_valid !== (m_q.size() != 0)) begin
                n_fail++;
                $display("FAIL b2b_state[%0d]: got count=%0d imem_a=%h v=%b want %0d/%h/%b", i,
                         bus.count, bus.imem_a, bus.inst_valid, m_q.size(), m_pc,
                         m_q.size() != 0);
            end else if (m_q.size() != 0) begin
                n_checks++;
                if (bus.inst_pc !== m_q[0] || bus.inst !== word_at(m_q[0])
                    || bus.inst_pc8 !== m_q[0] + 32'd8) begin
                    n_fail++;
                    $display("FAIL b2b_head[%0d]: got pc=%h inst=%h pc8=%h want %h/%h/%h", i,
                             bus.inst_pc, bus.inst, bus.inst_pc8, m_q[0], word_at(m_q[0]),
                             m_q[0] + 32'd8);
                end
            end
        end
        bus.redirect = 1'b0;
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_full_stall();
        test_redirect();
        test_redirect_held();
        test_wrap();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address; the memory returns read data combinationally in the same cycle.
- Captures each fetched word, with its PC, into a small show-ahead FIFO that feeds the decode stage over a valid/ready handshake.
- A redirect input (branch / PC write) flushes the queue and restarts fetch at the new address.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- RESET_PC, 32'h00000000, fetch address loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_a  output  32  fetch byte address to the instruction memory; always word aligned.
- imem_rd  input  32  instruction word returned combinationally for imem_a.
- redirect  input  1  request to restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored.
- inst_valid  output  1  the head entry is valid.
- inst  output  32  instruction word at the head.
- inst_pc  output  32  address of the head instruction.
- inst_pc8  output  32  inst_pc + 8, the ARM-visible PC value.
- inst_ready  input  1  decode accepts the head entry this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, applied immediately):
  - fetch_pc = RESET_PC & ~3.
  - Read and write pointers = 0, count = 0.
  - All storage entries cleared to 0.
  - Therefore inst_valid=0, inst=0, inst_pc=0, inst_pc8=8.
- imem_a = fetch_pc, combinational from the register, with bits [1:0] always 0.
- pop = inst_valid & inst_ready.
- push = ~redirect & ((count < DEPTH) | pop). A full queue accepts a push only when a pop occurs in the same cycle.
- On a push edge:
  - Entry {imem_rd, fetch_pc} is written at the write pointer.
  - The write pointer advances.
  - fetch_pc += 4, wrapping mod 2^32 (32'hFFFFFFFC -> 0).
- On a pop edge: the read pointer advances.
- Both pointers wrap modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Show-ahead output:
  - inst_valid = (count != 0).
  - inst and inst_pc come combinationally from the entry at the read pointer.
  - inst_pc8 = inst_pc + 8, mod 2^32.
- Full queue without a pop: fetch_pc holds and imem_a is stable. No word is lost or duplicated.
- Empty queue with inst_ready=1: nothing is popped and pointers hold. inst_valid=0, so decode must ignore inst.
- Latency:
  - A word at address X appears on inst one cycle after the edge where X is pushed.
  - After reset deasserts, inst_valid rises after the first clk edge.
- Redirect (takes priority over everything):
  - On that edge: pointers = 0, count = 0, fetch_pc = redirect_pc & ~3.
  - No push occurs.
  - A same-cycle handshake (inst_valid & inst_ready) is still treated as consumed by decode, but causes no additional state change.
  - The cycle after a redirect: inst_valid=0 and imem_a = new PC. The first new instruction becomes valid one further cycle later.
  - Redirect held for N cycles: fetch_pc is reloaded every cycle and the queue stays empty.
- Storage contents after a flush are don't-care; only inst_valid qualifies them.
- No internal FSM beyond pointer/count state.
- Expected size: roughly 150 lines of RTL.

Test Plan:
- Reset then free-run, inst_ready=1, memory word[i] = 32'hE0000000+i:
  - Cycle 1: inst_valid=1, inst_pc=0, inst=E0000000, inst_pc8=8.
  - Each later cycle: inst_pc steps +4 with matching inst. count stays at 1.
- inst_ready=0 from reset:
  - count goes 1,2,3,4 then holds at 4.
  - imem_a holds at 32'h10.
  - Then inst_ready=1 for 1 cycle: head pc 0 pops, pc 0x10 is pushed, count stays 4, imem_a becomes 0x14.
- Queue holding pcs 0x0..0xC, redirect=1 with redirect_pc=32'h0000010B:
  - Next cycle: count=0, inst_valid=0, imem_a=0x108.
  - Following cycle: inst_pc=0x108, inst_pc8=0x110.
- Redirect held for 3 cycles with differing targets:
  - inst_valid stays 0.
  - imem_a tracks each target one cycle later.
  - Fetch resumes from the last target.
- redirect to 32'hFFFFFFF8 with inst_ready=1: fetched PCs are FFFFFFF8, FFFFFFFC, 00000000, 00000004. inst_pc8 for FFFFFFFC = 00000004.
- Assert reset asynchronously mid-cycle with count=3: outputs immediately show inst_valid=0, count=0, imem_a=RESET_PC. Normal fetch resumes after deassertion.
